// File: rtl/exe_cmd_seq.sv
// Command sequencer: buffers commands in a FIFO and issues them one at a time to an execution unit.
// Define EXE_CMD_SEQ_ERRCNT_EN to add the saturating error counter output o_err_cnt.
module exe_cmd_seq #(
    parameter int M     = 4,
    parameter int N     = 2,
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic         i_clk,
    input  logic         i_rsn,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [N-1:0] i_cmd_oper,
    input  logic [M-1:0] i_cmd_argA,
    input  logic [M-1:0] i_cmd_argB,
    output logic [N-1:0] o_oper,
    output logic [M-1:0] o_argA,
    output logic [M-1:0] o_argB,
    input  logic [M-1:0] i_result,
    input  logic [3:0]   i_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic         o_busy
`ifdef EXE_CMD_SEQ_ERRCNT_EN
    ,
    output logic [7:0]   o_err_cnt
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LAT + 1);
    localparam logic [AW:0]   FULL     = DEPTH[AW:0];
    localparam logic [CW-1:0] LAT_LOAD = LAT[CW-1:0];

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;

    logic [N-1:0] fifo_oper [DEPTH];
    logic [M-1:0] fifo_a    [DEPTH];
    logic [M-1:0] fifo_b    [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;

    logic push;
    logic pop;
    logic capture;

    // Ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
    assign o_cmd_ready = (count < FULL);
    assign push        = i_cmd_valid && o_cmd_ready;
    assign pop         = (state == IDLE) && (count != '0);
    assign capture     = (state == WAIT) && (cnt == '0);
    assign o_busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_oper[wr_ptr] <= i_cmd_oper;
            fifo_a[wr_ptr]    <= i_cmd_argA;
            fifo_b[wr_ptr]    <= i_cmd_argB;
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state        <= IDLE;
            cnt          <= '0;
            o_oper       <= '0;
            o_argA       <= '0;
            o_argB       <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_result <= '0;
            o_rsp_status <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_oper <= fifo_oper[rd_ptr];
                        o_argA <= fifo_a[rd_ptr];
                        o_argB <= fifo_b[rd_ptr];
                        cnt    <= LAT_LOAD;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    // Counter reaching zero is itself one more edge, hence LAT+1 edges to capture.
                    if (capture) begin
                        o_rsp_result <= i_result;
                        o_rsp_status <= i_status;
                        o_rsp_valid  <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef EXE_CMD_SEQ_ERRCNT_EN
    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            o_err_cnt <= '0;
        end else if (capture && (i_status != 4'd0) && (o_err_cnt != 8'hFF)) begin
            o_err_cnt <= o_err_cnt + 8'd1;
        end
    end
`endif

endmodule
